// File: rtl/dff_chain_pkg.sv
// dff_chain_pkg: shared state encoding and WIDTH limits for the flip-flop chain loader.
package dff_chain_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/loader_bit_counter.sv
// loader_bit_counter: counts shifted bits; tc flags the cycle presenting the last bit.
module loader_bit_counter #(
  parameter int CW = 4,
  parameter int LAST = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  logic [CW-1:0] count;
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= count + 1'b1;
  assign tc = count == CW'(LAST);
endmodule

// File: rtl/dff_chain_loader.sv
// dff_chain_loader: serialises a parallel word LSB-first into a downstream DFF chain.
// Define DFF_CHAIN_LOADER_PARITY_EN to append an even-parity bit after the data bits.
module dff_chain_loader
  import dff_chain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             abort,
  output logic             ser_d,
  output logic             ser_en,
  output logic             busy,
  output logic             done
);
`ifdef DFF_CHAIN_LOADER_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  logic [N-1:0] load_word, sreg, sreg_nx;
`ifdef DFF_CHAIN_LOADER_PARITY_EN
  assign load_word = {^in_data, in_data};
`else
  assign load_word = in_data;
`endif
  state_t state, state_nx;
  logic hs, tc, ser_d_nx, ser_en_nx, done_nx;
  assign hs = state == IDLE && in_ready && in_valid;
  loader_bit_counter #(.CW(CW), .LAST(N - 1)) u_cnt (
    .clk(clk),
    .reset(reset),
    .clear(hs),
    .enable(state == SHIFT),
    .tc(tc)
  );
  // Outputs are registered from next-state values so each bit appears the cycle after its decision.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      sreg <= '0;
      in_ready <= 1'b0;
      ser_en <= 1'b0;
      ser_d <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      sreg <= sreg_nx;
      in_ready <= state_nx == IDLE;
      ser_en <= ser_en_nx;
      ser_d <= ser_d_nx;
      busy <= state_nx != IDLE;
      done <= done_nx;
    end
  always_comb begin
    state_nx = state;
    sreg_nx = sreg;
    ser_en_nx = 1'b0;
    ser_d_nx = 1'b0;
    done_nx = 1'b0;
    case (state)
      IDLE: if (hs) begin
        state_nx = SHIFT;
        sreg_nx = load_word;
        ser_en_nx = 1'b1;
        ser_d_nx = load_word[0];
      end
      SHIFT: begin
        sreg_nx = sreg >> 1;
        if (abort) state_nx = IDLE;
        else if (tc) begin
          state_nx = DONE;
          done_nx = 1'b1;
        end else begin
          ser_en_nx = 1'b1;
          ser_d_nx = sreg[1];
        end
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dff_chain_loader.sv
// tb_dff_chain_loader: directed checks of dff_chain_loader at WIDTH=8.
module tb_dff_chain_loader;
`ifdef DFF_CHAIN_LOADER_PARITY_EN
  localparam int N = 9;
  localparam logic [31:0] E_A5 = 32'h0A5, E_07 = 32'h107;
`else
  localparam int N = 8;
  localparam logic [31:0] E_A5 = 32'hA5, E_07 = 32'h07;
`endif
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, abort = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, ser_d, ser_en, busy, done;
  int n_chk = 0, n_err = 0;
  int n_en, n_done, done_at, rdy_at, bad_d, bad_b, junk;
  logic first_en;
  logic [N-1:0] bits;
  always #5 clk = ~clk;
  dff_chain_loader #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .abort(abort), .ser_d(ser_d), .ser_en(ser_en),
    .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // ab: cycle after whose sample abort is raised for one edge (0 = with the handshake, -1 = never)
  task automatic xfer(input logic [7:0] d, input int ab, input logic hold, input logic [7:0] d2);
    n_en = 0; n_done = 0; done_at = 0; rdy_at = 0; bad_d = 0; bad_b = 0; bits = '0; first_en = 1'b0;
    in_valid = 1'b1; in_data = d; abort = ab == 0;
    for (int c = 1; c <= 40 && rdy_at == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        in_valid = hold; in_data = d2; first_en = ser_en;
      end
      abort = 1'b0;
      if (ser_en) begin
        if (n_en < N) bits[n_en] = ser_d;
        n_en++;
      end else if (ser_d) bad_d++;
      if (busy !== (ser_en | done)) bad_b++;
      if (done) begin
        n_done++; done_at = c;
      end
      if (in_ready) rdy_at = c;
      if (c == ab) abort = 1'b1;
    end
  endtask
  initial begin
    #1 chk("reset_outs", {27'b0, in_ready, ser_en, ser_d, busy, done}, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {31'b0, in_ready}, 32'h1);
    chk("busy_idle", {31'b0, busy}, 32'h0);
    xfer(8'hA5, -1, 1'b0, 8'h00);
    chk("a5_bits", 32'(bits), E_A5);
    chk("a5_nen", n_en, N);
    chk("a5_done_cnt", n_done, 1);
    chk("a5_done_at", done_at, N + 1);
    chk("a5_ready_at", rdy_at, N + 2);
    chk("a5_d_when_idle", bad_d, 0);
    chk("a5_busy", bad_b, 0);
    xfer(8'h07, -1, 1'b0, 8'h00);
    chk("07_bits", 32'(bits), E_07);
    chk("07_nen", n_en, N);
    chk("07_ready_at", rdy_at, N + 2);
    xfer(8'hFF, 3, 1'b0, 8'h00);
    chk("abort_nen", n_en, 3);
    chk("abort_bits", 32'(bits), 32'h7);
    chk("abort_no_done", n_done, 0);
    chk("abort_ready_at", rdy_at, 4);
    chk("abort_busy", bad_b, 0);
    xfer(8'hA5, -1, 1'b1, 8'h00);
    chk("hold_bits", 32'(bits), E_A5);
    chk("hold_nen", n_en, N);
    chk("hold_ready_at", rdy_at, N + 2);
    xfer(8'h00, -1, 1'b0, 8'h00);
    chk("b2b_first_en", {31'b0, first_en}, 32'h1);
    chk("b2b_bits", 32'(bits), 32'h0);
    chk("b2b_nen", n_en, N);
    chk("b2b_ready_at", rdy_at, N + 2);
    xfer(8'hA5, 0, 1'b0, 8'h00);
    chk("abort_hs_bits", 32'(bits), E_A5);
    chk("abort_hs_done", n_done, 1);
    xfer(8'h3C, N + 1, 1'b0, 8'h00);
    chk("abort_done_cnt", n_done, 1);
    chk("abort_done_ready", rdy_at, N + 2);
    in_valid = 1'b1; in_data = 8'hFF;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    chk("rst_mid_en_before", {31'b0, ser_en}, 32'h1);
    #2 reset = 1'b0;
    #1 chk("rst_mid_async", {27'b0, in_ready, ser_en, ser_d, busy, done}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", {31'b0, in_ready}, 32'h1);
    junk = 0;
    for (int c = 0; c < 12; c++) begin
      if (done || ser_en || busy) junk++;
      @(negedge clk);
    end
    chk("rst_mid_quiet", junk, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dff_chain_loader.md
DFF_CHAIN_LOADER -- requirements
Module: dff_chain_loader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: the number of data bits serialised per transfer (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1: a parallel word is offered.
REQ-005 The block SHALL have port in_ready, output, 1: the block accepts a word this cycle.
REQ-006 The block SHALL have port in_data, input, WIDTH: the parallel word, captured on handshake.
REQ-007 The block SHALL have port abort, input, 1: cancels a transfer in progress.
REQ-008 The block SHALL have port ser_d, output, 1: serial bit driven to the d input of the downstream flip-flop chain.
REQ-009 The block SHALL have port ser_en, output, 1: shift-enable for the downstream chain.
REQ-010 The block SHALL have port busy, output, 1: high in the SHIFT and DONE states.
REQ-011 The block SHALL have port done, output, 1: one-cycle pulse when a transfer completes normally.

Function
REQ-012 The block SHALL register all outputs; there SHALL be no combinational path from an input to an output.
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
- In IDLE, in_ready SHALL be 1.
- A handshake is in_valid=1 and in_ready=1 at a rising edge.
- On a handshake, the block SHALL capture in_data into the shift register, clear the bit counter, clear in_ready and enter SHIFT.
REQ-014 In SHIFT, on each cycle:
- ser_en SHALL be 1.
- ser_d SHALL carry the shift register bit 0 (LSB first).
- The shift register SHALL shift right by one and the counter SHALL increment.
REQ-015 SHIFT SHALL last exactly N cycles (N=WIDTH, or WIDTH+1 under REQ-024); after the Nth bit the FSM SHALL enter DONE.
REQ-016 In DONE, the block SHALL hold done=1 and ser_en=0 for exactly one cycle, then SHALL return to IDLE with in_ready=1.
REQ-017 Latency: for a handshake at edge E, ser_en SHALL be high in cycles E+1..E+N, done SHALL be high in cycle E+N+1, and in_ready SHALL be high again from cycle E+N+2.
REQ-018 in_valid outside IDLE SHALL be ignored; in_data SHALL be sampled only at the handshake edge.
REQ-019 If abort=1 at an edge while in SHIFT:
- The bit presented in that cycle still counts as shifted.
- The next state SHALL be IDLE with ser_en=0, in_ready=1 and no done pulse.
REQ-020 abort SHALL be ignored in IDLE and DONE; abort together with a handshake in IDLE SHALL still start the transfer.
REQ-021 The counter width SHALL be $clog2(WIDTH+2), and the counter SHALL never wrap within a transfer.
REQ-022 When ser_en=0, ser_d SHALL be 0.

Reset
REQ-023 While reset=0, the block SHALL immediately force (asynchronously):
- state to IDLE;
- in_ready, ser_en, ser_d, busy and done to 0;
- shift register and counter to 0.
in_ready SHALL rise at the first rising edge after reset is released. Reset asserted mid-transfer SHALL abandon the transfer with no done pulse.

Configuration
REQ-024 With the macro DFF_CHAIN_LOADER_PARITY_EN defined:
- After the WIDTH data bits, the block SHALL shift one extra bit: the even-parity bit (XOR of the captured in_data).
- N SHALL be WIDTH+1.
Without the macro, no parity logic SHALL exist and N SHALL be WIDTH.

Structure
REQ-025 A shared package dff_chain_pkg SHALL hold the state enum type (IDLE, SHIFT, DONE) and the WIDTH limits (MIN 2, MAX 32).
REQ-026 The bit counter SHALL be a separate sub-module, loader_bit_counter, with clear, enable and a terminal-count output; the FSM and shift register SHALL remain in dff_chain_loader.

Verification (WIDTH=8)
REQ-027 Basic transfer: after reset, in_data=8'hA5 with in_valid=1 -> ser_d=1,0,1,0,0,1,0,1 over 8 ser_en cycles, then done=1 for 1 cycle, then in_ready=1.
REQ-028 Parity (PARITY_EN defined): in_data=8'h07 -> 9 ser_en cycles with bits 1,1,1,0,0,0,0,0,1; without the macro -> 8 cycles.
REQ-029 Abort: in_data=8'hFF, abort=1 in the 3rd SHIFT cycle -> exactly 3 ser_en cycles, no done pulse, in_ready=1 on the next cycle.
REQ-030 Ignored input: in_valid held high with in_data changing to 8'h00 mid-transfer -> serial output is unchanged; the second word (8'h00) is accepted only in IDLE; back-to-back transfers are spaced N+2 cycles apart.
REQ-031 Reset mid-transfer: reset=0 during the 4th SHIFT cycle -> all outputs 0 immediately (without waiting for a clock edge); after release, in_ready=1 at the first edge and no done pulse occurs.
